// File: rtl/vram_pkg.sv
// vram_pkg: shared constants and page-index helpers for vram_multipage
package vram_pkg;
  localparam logic [31:0] CTRL_ADDRESS_DEF = 32'h0fff_fff0;
  localparam int CTRL_PENDING = 0;
  localparam int CTRL_DISPLAY_LSB = 2;
  localparam int CTRL_DRAW_LSB = 4;
  localparam int PW = 2;
  typedef logic [PW-1:0] page_t;
  function automatic page_t next_page(page_t p, int pages);
    return (int'(p) == pages - 1) ? '0 : p + page_t'(1);
  endfunction
endpackage

// File: rtl/vram_bank.sv
// vram_bank: single-port synchronous RAM, one-cycle read, read-during-write returns old data
module vram_bank #(
  parameter int DATA_WIDTH = 24,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  i_clock,
  input  logic                  en,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  always_ff @(posedge i_clock) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      rdata <= mem[addr];
    end
  end
endmodule

// File: rtl/vram_multipage.sv
// vram_multipage: PAGES-page framebuffer with vblank-deferred page flips.
// Optional VRAM_READBACK_EN enables CPU pixel reads from the draw page.
module vram_multipage
  import vram_pkg::*;
#(
  parameter int          DATA_WIDTH   = 24,
  parameter int          ADDR_WIDTH   = 16,
  parameter int          PAGES        = 2,
  parameter logic [31:0] CTRL_ADDRESS = CTRL_ADDRESS_DEF
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic [ADDR_WIDTH-1:0] i_video_address,
  input  logic                  i_video_enable,
  input  logic                  i_video_vblank,
  output logic [DATA_WIDTH-1:0] o_video_rdata,
  input  logic                  i_request,
  input  logic                  i_rw,
  input  logic [31:0]           i_address,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic                  o_ready
);
  page_t display, draw, vid_page;
  logic pending, is_ctrl, accept, cpu_en, vid_valid;
  logic [ADDR_WIDTH-1:0] cpu_idx;
  logic [DATA_WIDTH-1:0] ctrl_word, rdata_q, vid_hold;
  logic [DATA_WIDTH-1:0] bank_q [4];
  assign is_ctrl = i_address == CTRL_ADDRESS;
  assign accept = i_request && !o_ready && !(pending && !is_ctrl);
  assign cpu_idx = i_address[ADDR_WIDTH+1:2];
`ifdef VRAM_READBACK_EN
  page_t rd_page;
  logic rd_pix;
  assign cpu_en = accept && !is_ctrl;
  assign o_rdata = rd_pix ? bank_q[rd_page] : rdata_q;
`else
  assign cpu_en = accept && !is_ctrl && i_rw;
  assign o_rdata = rdata_q;
`endif
  always_comb begin
    ctrl_word = '0;
    ctrl_word[CTRL_PENDING] = pending;
    ctrl_word[CTRL_DISPLAY_LSB +: PW] = display;
    ctrl_word[CTRL_DRAW_LSB +: PW] = draw;
  end
  // Draw and display never coincide, so each bank has exactly one owner or is idle.
  for (genvar p = 0; p < 4; p++) begin : g_page
    if (p < PAGES) begin : g_bank
      logic is_draw, is_disp;
      assign is_draw = draw == page_t'(p);
      assign is_disp = display == page_t'(p);
      vram_bank #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_bank (
        .i_clock(i_clock),
        .en(is_draw ? cpu_en : is_disp && i_video_enable),
        .we(is_draw && cpu_en && i_rw),
        .addr(is_draw ? cpu_idx : i_video_address),
        .wdata(i_wdata),
        .rdata(bank_q[p])
      );
    end else begin : g_none
      assign bank_q[p] = '0;
    end
  end
  assign o_video_rdata = vid_valid ? bank_q[vid_page] : vid_hold;
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      display <= '0;
      draw <= page_t'(1);
      pending <= 1'b0;
      o_ready <= 1'b0;
      rdata_q <= '0;
      vid_valid <= 1'b0;
      vid_page <= '0;
      vid_hold <= '0;
`ifdef VRAM_READBACK_EN
      rd_pix <= 1'b0;
      rd_page <= '0;
`endif
    end else begin
      o_ready <= accept;
      vid_valid <= i_video_enable;
      vid_page <= display;
      vid_hold <= o_video_rdata;
      if (accept) rdata_q <= (is_ctrl && !i_rw) ? ctrl_word : '0;
`ifdef VRAM_READBACK_EN
      if (accept) rd_pix <= !is_ctrl && !i_rw;
      if (accept) rd_page <= draw;
`endif
      // A flip consumes the old pending bit, so a same-cycle request waits a frame.
      if (i_video_vblank && pending) begin
        display <= draw;
        draw <= next_page(draw, PAGES);
        pending <= 1'b0;
      end else if (accept && is_ctrl && i_rw && i_wdata[CTRL_PENDING]) begin
        pending <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_vram_multipage.sv
// tb_vram_multipage: table-driven and sequence checks on a 2-page and a 3-page instance
module tb_vram_multipage;
  localparam logic [31:0] CA = 32'h0fff_fff0;
`ifdef VRAM_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic req [2], rw [2], ven [2], vb [2], rdy [2];
  logic [31:0] addr [2];
  logic [23:0] wd [2], rd [2], vrd [2];
  logic [7:0] vaddr [2];
  int checks = 0, errors = 0;
  typedef struct {string nm; logic [23:0] data; bit chk;} exp_t;
  exp_t sbq [$];
  typedef struct {bit rw; logic [31:0] a; logic [23:0] wd; logic [23:0] ex; bit chk; string nm;} vec_t;
  vec_t tbl [7];
  always #5 clk = ~clk;
  vram_multipage #(.DATA_WIDTH(24), .ADDR_WIDTH(8), .PAGES(2)) u2 (
    .i_clock(clk), .i_reset(rst), .i_video_address(vaddr[0]), .i_video_enable(ven[0]),
    .i_video_vblank(vb[0]), .o_video_rdata(vrd[0]), .i_request(req[0]), .i_rw(rw[0]),
    .i_address(addr[0]), .i_wdata(wd[0]), .o_rdata(rd[0]), .o_ready(rdy[0]));
  vram_multipage #(.DATA_WIDTH(24), .ADDR_WIDTH(8), .PAGES(3)) u3 (
    .i_clock(clk), .i_reset(rst), .i_video_address(vaddr[1]), .i_video_enable(ven[1]),
    .i_video_vblank(vb[1]), .o_video_rdata(vrd[1]), .i_request(req[1]), .i_rw(rw[1]),
    .i_address(addr[1]), .i_wdata(wd[1]), .o_rdata(rd[1]), .o_ready(rdy[1]));
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic op(int d, bit w, logic [31:0] a, logic [23:0] wdat, logic [23:0] ex, bit c, string nm);
    int n;
    exp_t e;
    sbq.push_back('{nm, ex, c});
    @(negedge clk);
    req[d] = 1'b1; rw[d] = w; addr[d] = a; wd[d] = wdat;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!rdy[d] && n < 20);
    e = sbq.pop_front();
    chk({e.nm, "_latency"}, n, 1);
    if (rdy[d] && e.chk) chk({e.nm, "_data"}, rd[d], e.data);
    @(posedge clk); #1;
    chk({e.nm, "_pulse"}, rdy[d], 1'b0);
    req[d] = 1'b0;
  endtask
  task automatic vblank(int d);
    @(negedge clk); vb[d] = 1'b1;
    @(negedge clk); vb[d] = 1'b0;
  endtask
  task automatic vid(int d, logic [7:0] w, logic [23:0] ex, string nm);
    @(negedge clk); ven[d] = 1'b1; vaddr[d] = w;
    @(posedge clk); #1;
    chk(nm, vrd[d], ex);
    @(negedge clk); ven[d] = 1'b0;
  endtask
  initial begin
    logic [23:0] seq3 [3];
    for (int d = 0; d < 2; d++) begin
      req[d] = 0; rw[d] = 0; ven[d] = 0; vb[d] = 0; addr[d] = 0; wd[d] = 0; vaddr[d] = 0;
    end
    tbl[0] = '{0, CA, 24'h0, 24'h10, 1, "ctrl_reset"};
    tbl[1] = '{1, 32'h40, 24'h111111, 24'h0, 0, "wr40"};
    tbl[2] = '{0, 32'h40, 24'h0, RB ? 24'h111111 : 24'h0, 1, "rd40"};
    tbl[3] = '{1, 32'h44, 24'h222222, 24'h0, 0, "wr44"};
    tbl[4] = '{0, 32'h444, 24'h0, RB ? 24'h222222 : 24'h0, 1, "rd_wrap"};
    tbl[5] = '{1, CA, 24'h0, 24'h0, 0, "ctrl_wr0"};
    tbl[6] = '{0, CA, 24'h0, 24'h10, 1, "ctrl_nop"};
    seq3[0] = 24'h24; seq3[1] = 24'h08; seq3[2] = 24'h10;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("reset_ready", rdy[0], 1'b0);
    chk("reset_rdata", rd[0], 24'h0);
    chk("reset_vrdata", vrd[0], 24'h0);
    for (int i = 0; i < 7; i++) op(0, tbl[i].rw, tbl[i].a, tbl[i].wd, tbl[i].ex, tbl[i].chk, tbl[i].nm);
    op(0, 1, CA, 24'h1, 0, 0, "ctrl_flip");
    op(0, 0, CA, 0, 24'h11, 1, "ctrl_pending");
    @(negedge clk);
    req[0] = 1; rw[0] = 1; addr[0] = 32'h40; wd[0] = 24'hABCDEF;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("stall_ready", rdy[0], 1'b0);
    end
    @(negedge clk); vb[0] = 1'b1;
    @(posedge clk); #1;
    chk("stall_flip_edge", rdy[0], 1'b0);
    @(negedge clk); vb[0] = 1'b0;
    @(posedge clk); #1;
    chk("stall_release", rdy[0], 1'b1);
    @(posedge clk); #1;
    chk("stall_pulse", rdy[0], 1'b0);
    req[0] = 0;
    op(0, 0, CA, 0, 24'h04, 1, "ctrl_after_flip");
    op(0, 0, 32'h40, 0, RB ? 24'hABCDEF : 24'h0, 1, "rd_new_draw");
    vid(0, 8'h10, 24'h111111, "vid_page1_w10");
    repeat (3) @(posedge clk);
    #1 chk("vid_hold", vrd[0], 24'h111111);
    vid(0, 8'h11, 24'h222222, "vid_page1_w11");
    op(0, 1, CA, 24'h1, 0, 0, "ctrl_flip_a");
    op(0, 1, CA, 24'h1, 0, 0, "ctrl_flip_b");
    op(0, 0, CA, 0, 24'h05, 1, "ctrl_double");
    vblank(0);
    op(0, 0, CA, 0, 24'h10, 1, "ctrl_one_flip");
    vblank(0);
    op(0, 0, CA, 0, 24'h10, 1, "ctrl_no_flip");
    vid(0, 8'h10, 24'hABCDEF, "vid_page0_w10");
    @(negedge clk);
    req[0] = 1; rw[0] = 1; addr[0] = CA; wd[0] = 24'h1; vb[0] = 1'b1;
    @(posedge clk); #1;
    chk("same_cycle_ready", rdy[0], 1'b1);
    @(negedge clk); vb[0] = 1'b0; req[0] = 0;
    op(0, 0, CA, 0, 24'h11, 1, "same_cycle_deferred");
    vblank(0);
    op(0, 0, CA, 0, 24'h04, 1, "same_cycle_next");
    op(0, 1, CA, 24'h1, 0, 0, "ctrl_flip_c");
    op(0, 0, CA, 0, 24'h05, 1, "pre_reset");
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_reset_ready", rdy[0], 1'b0);
    chk("mid_reset_vrdata", vrd[0], 24'h0);
    @(negedge clk); rst = 1'b0;
    op(0, 0, CA, 0, 24'h10, 1, "post_reset");
    for (int i = 0; i < 3; i++) begin
      op(1, 1, CA, 24'h1, 0, 0, "p3_flip");
      vblank(1);
      op(1, 0, CA, 0, seq3[i], 1, $sformatf("p3_seq%0d", i));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/vram_multipage.md
Name: vram_multipage

Overview:
- Parametrised successor to the two-page framebuffer VRAM.
- Holds PAGES framebuffer pages of 2**ADDR_WIDTH words × DATA_WIDTH bits.
- One page is scanned out to the video generator. A different page (the draw page) is owned by the CPU.
- CPU-requested page flips are deferred until the next vertical-blank pulse, so there is no tearing. CPU pixel accesses stall while a flip is pending.

Parameters:
- DATA_WIDTH, 24, pixel word width.
- ADDR_WIDTH, 16, word address width per page; depth = 2**ADDR_WIDTH.
- PAGES, 2, number of pages; legal range 2..4 (3 = triple buffering).
- CTRL_ADDRESS, 32'h0fff_fff0, CPU byte address of the control register.

Ports:
- i_clock  in  1  system clock; all logic on the rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_video_address  in  ADDR_WIDTH  scan-out word address.
- i_video_enable  in  1  scan-out read strobe.
- i_video_vblank  in  1  one-cycle pulse at the start of vertical blank.
- o_video_rdata  out  DATA_WIDTH  scan-out pixel, registered.
- i_request  in  1  CPU request; held high until o_ready is seen.
- i_rw  in  1  1 = write, 0 = read.
- i_address  in  32  CPU byte address.
- i_wdata  in  DATA_WIDTH  CPU write data.
- o_rdata  out  DATA_WIDTH  CPU read data; valid while o_ready is high.
- o_ready  out  1  one-cycle completion pulse.

Behaviour:
- Reset values: display=0, draw=1, pending=0, o_ready=0, o_rdata=0, o_video_rdata=0. Asserting reset mid-pending drops the pending flip; a CPU access in flight is lost (no o_ready).
- Word index = i_address[ADDR_WIDTH+1:2]. Pixel access = any address other than CTRL_ADDRESS (full 32-bit compare). Upper address bits are ignored, so addresses wrap modulo the page size.
- Acceptance: a request is accepted in a cycle where i_request=1, o_ready=0 and not stalled. o_ready pulses exactly one cycle later. A request still held during the o_ready cycle is not re-accepted.
- Stall: a pixel access is stalled while pending=1, with o_ready held low. Control-register accesses never stall.
- Pixel write: writes i_wdata into the draw page at the word index.
- Pixel read: returns the draw page word at the index via o_rdata (latency 1); gated by VRAM_READBACK_EN.
- Control write: bit0=1 with pending=0 sets pending. bit0=1 with pending=1 is ignored. bit0=0 has no effect.
- Control read, o_rdata: [0]=pending, [3:2]=display, [5:4]=draw, others 0.
- Flip: on i_video_vblank with pending=1, display<=draw, draw<=(draw+1) mod PAGES, pending<=0.
- A control write and vblank in the same cycle set pending, with the flip applied at the next vblank, not this one.
- Invariant: draw != display at all times.
- Scan-out: reads the display page at i_video_address when i_video_enable=1, latency 1. The output mux uses the display index delayed by one cycle. With i_video_enable=0, o_video_rdata holds its value.
- Page RAM port usage: the draw page port is driven by the CPU, the display page port by video, and idle pages are disabled.
- Read-during-write on the same page and address returns old data.

Optional Feature:
- Macro: VRAM_READBACK_EN.
- Defined: pixel reads return draw-page data as specified above.
- Undefined: pixel reads still complete with o_ready (same stall rules) but o_rdata=0. The CPU read mux and page read path are removed. Control reads are unaffected.

Decomposition:
- Package vram_pkg: CTRL_ADDRESS default, control bit positions (CTRL_PENDING=0, CTRL_DISPLAY_LSB=2, CTRL_DRAW_LSB=4), page-index width constant (2 bits).
- Sub-module vram_bank: single-port synchronous RAM, DATA_WIDTH × 2**ADDR_WIDTH, one-cycle read, write enable. Instantiated PAGES times via generate.

Test Plan:
- Reset, then read the control register -> o_rdata=0x10 (display 0, draw 1, pending 0); o_ready one cycle after request.
- Write 0xABCDEF to byte address 0x40, then read it back (READBACK_EN) -> o_rdata=0xABCDEF. With video_enable at word 0x10 -> o_video_rdata unchanged (page 0 untouched).
- Control write 1, then pixel write -> o_ready stays low. Pulse vblank -> write completes 1 cycle later into the new draw page. Control read -> display=1, draw=0, pending=0.
- PAGES=3: three flip+vblank cycles -> display sequence 1,2,0 and draw sequence 2,0,1.
- Control write 1 in the same cycle as vblank -> no flip that frame; flip occurs at the next vblank.
- Control write 1 twice before vblank -> exactly one flip. Reset asserted while pending -> pending=0, display=0.
